// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// register map of the APB-attached UART and GPIO slaves.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [APB_ADDR_W-1:0] UART_RXDATA_ADDR = 32'h0000_0078;
  localparam logic [APB_ADDR_W-1:0] UART_TXDATA_ADDR = 32'h0000_0079;
  localparam logic [APB_ADDR_W-1:0] UART_STATUS_ADDR = 32'h0000_007A;
  localparam logic [APB_ADDR_W-1:0] UART_CTRL_ADDR   = 32'h0000_007B;
  localparam logic [APB_ADDR_W-1:0] GPIO_OUT_ADDR    = 32'h0000_0080;
  localparam logic [APB_ADDR_W-1:0] GPIO_IN_ADDR     = 32'h0000_0084;
  localparam logic [APB_ADDR_W-1:0] GPIO_DIR_ADDR    = 32'h0000_0088;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT-th one. TIMEOUT=0 removes the counter entirely.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{pclk, rst, clr, en};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] cnt;

      // Saturates at TIMEOUT-1; the owner aborts on that same edge.
      always_ff @(posedge pclk) begin
        if (!rst || clr)         cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
      end

      assign expired = (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns one command-port request into a single SETUP/ACCESS
// transfer and returns a one-cycle response, aborting on wait-state timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = 64
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              apb_done,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] padd,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslevrr
);

  apb_state_e state, state_nxt;
  logic       ready_q;
  logic       accept, done_ok, abort;
  logic       tmo_exp;

  always_ff @(posedge pclk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_ok   = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          done_ok   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_exp) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .pclk    (pclk),
    .rst     (rst),
    .clr     (accept),
    .en      (state == ST_ACCESS && !pready),
    .expired (tmo_exp)
  );

  // ready_q keeps cmd_ready low until the first edge after reset releases.
  assign cmd_ready = ready_q && (state == ST_IDLE);
  assign psel      = (state != ST_IDLE);
  assign penable   = (state == ST_ACCESS);

  always_ff @(posedge pclk) begin
    if (!rst) begin
      ready_q     <= 1'b0;
      pwrite      <= 1'b0;
      padd        <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      apb_done    <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      rsp_valid <= done_ok || abort;
      apb_done  <= done_ok || abort;
      if (accept) begin
        pwrite <= cmd_write;
        padd   <= cmd_addr;
        pwdata <= cmd_wdata;
        pstrb  <= cmd_write ? cmd_strb : '0;
      end
      // Response fields persist until the next completion or abort.
      if (done_ok) begin
        rsp_err     <= pslevrr;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= (!pwrite && !pslevrr) ? prdata : '0;
      end else if (abort) begin
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end
    end
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that issues single read/write transfers to the APB-attached UART and GPIO slaves on behalf of a simple command/response port.
- Replaces hand-driven psel/penable sequencing in the integration layer and in benches.
- Owns the SETUP/ACCESS protocol, wait-state handling, error capture, and a wait-state timeout watchdog.

Parameters:
- ADDR_W, 32, width of padd / cmd_addr
- DATA_W, 32, width of pwdata / prdata / cmd_wdata / rsp_rdata
- STRB_W, DATA_W/8, byte-strobe width
- TIMEOUT, 64, max ACCESS cycles with pready=0 before abort; 0 disables the watchdog

Ports:
- pclk  in  1  APB clock; the only clock
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  STRB_W  write byte strobes
- rsp_valid  out  1  one-cycle pulse, transfer finished
- rsp_rdata  out  DATA_W  read data; 0 for writes, errors and timeouts
- rsp_err  out  1  slave error or timeout, valid with rsp_valid
- rsp_timeout  out  1  watchdog abort, valid with rsp_valid
- apb_done  out  1  one-cycle pulse, same cycle as rsp_valid
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- padd  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pstrb  out  STRB_W  APB strobes; forced to 0 on reads
- pready  in  1  slave ready
- prdata  in  DATA_W  slave read data
- pslevrr  in  1  slave error, sampled only with pready

Behaviour:
- Reset (rst=0 at posedge): state=IDLE.
  - All outputs 0 except cmd_ready.
  - cmd_ready is 0 during reset and 1 in IDLE thereafter.
  - Timeout counter is cleared.
  - Reset mid-transfer drops psel and penable at that same edge; no response is generated.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: cmd_ready=1. On accept, latch write/addr/wdata/strb into the APB output registers and go to SETUP.
  - SETUP: exactly one cycle with psel=1, penable=0. Go to ACCESS.
  - ACCESS: psel=1, penable=1. padd, pwrite, pwdata and pstrb are held stable from SETUP through the end of ACCESS.
    - pready=1: complete the transfer and go to IDLE.
    - pready=0: stay in ACCESS and increment the counter.
- Completion at posedge with pready=1:
  - At that same edge: psel and penable go to 0; rsp_valid and apb_done go to 1 for one cycle.
  - rsp_err = pslevrr.
  - rsp_rdata = prdata if read and !pslevrr, else 0.
  - rsp_timeout = 0.
- Timeout (TIMEOUT>0): if the counter reaches TIMEOUT-1 with pready still 0, abort at that edge.
  - Outputs: psel and penable go to 0; rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The counter resets on each SETUP entry.
- Latency:
  - Accept edge N.
  - SETUP occupies cycle N..N+1.
  - ACCESS starts at N+1.
  - With zero wait states, the response pulse appears after edge N+2.
  - Each wait state adds 1 cycle.
- Throughput: cmd_ready returns high in the cycle of rsp_valid. The minimum period is 3 cycles per transfer; there are no back-to-back SETUPs without an IDLE cycle.
- cmd_* inputs are ignored outside IDLE. Held cmd_valid is accepted once per IDLE visit.
- rsp_rdata, rsp_err and rsp_timeout hold their value until the next response. rsp_valid and apb_done are strictly single-cycle.
- The block has no internal buffering. The consumer must sample rsp_* in the rsp_valid cycle.

Decomposition:
- Shared package apb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2
  - default ADDR_W/DATA_W
  - UART/GPIO register address constants shared with uart_apb and benches
- One optional sub-module, apb_timeout_cnt: counter with clear, enable and expiry flag, parameterised by TIMEOUT.
- All else stays inline.

Test Plan:
- Write, zero wait: cmd_write=1, addr=0x79, wdata=0x2AAA, strb=0xF.
  - Required: SETUP one cycle then ACCESS, padd/pwdata stable throughout.
  - Required: rsp_valid and apb_done pulse 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read, 2 wait states: addr=0x78, slave returns prdata=0xA5 with pready on the third ACCESS cycle.
  - Required: rsp_rdata=0xA5, rsp_err=0, pstrb=0 during the transfer.
  - Required: total 5 cycles from accept to response.
- Slave error on read: pready=1 with pslevrr=1, prdata=0xDEAD.
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout with TIMEOUT=4 and pready stuck at 0.
  - Required: abort after 4 ACCESS cycles; psel=0; rsp_err=1, rsp_timeout=1.
  - Required: the next command is accepted normally.
- Reset mid-ACCESS: assert rst=0 during a wait state.
  - Required: psel, penable and rsp_valid are 0 after the edge; cmd_ready=1 one cycle after rst returns high.
- Back-to-back with held cmd_valid: two commands issued.
  - Required: accept, SETUP, ACCESS, then IDLE/accept in the same cycle as the first rsp_valid.
  - Required: the second SETUP follows with no overlap of psel phases.
